// File: rtl/serial_key_schedule.sv
// Serial round-key generator for the SWAN64 datapath: holds the master key and
// emits one SIDE_SIZE-bit round key per round, advancing on each next pulse.
module serial_key_schedule #(
  parameter int                    BLOCK_SIZE = 64,
  parameter int                    SIDE_SIZE  = BLOCK_SIZE / 2,
  parameter int                    KEY_SIZE   = 128,
  parameter int                    ROUNDS     = 32,
  parameter logic [SIDE_SIZE-1:0]  DELTA      = 32'h9E3779B9,
  parameter int                    CNT_W      = $clog2(ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [0:KEY_SIZE-1]    key_in,
  input  logic                   next,
  output logic [0:SIDE_SIZE-1]   rk,
  output logic                   rk_en,
  output logic [CNT_W-1:0]       round_idx,
  output logic                   last,
  output logic                   done
);

  // state  | meaning
  // IDLE   | no key loaded since reset; outputs quiet
  // ACTIVE | presenting round key cnt on rk
  // DONE   | all ROUNDS keys presented; waiting for load
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  state_t                state, state_nxt;
  logic [0:KEY_SIZE-1]   key_q;
  logic [SIDE_SIZE-1:0]  s_q;
  logic [CNT_W-1:0]      cnt;
  logic                  advance;
  logic [SIDE_SIZE-1:0]  word_new;

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    if (load) begin
      state_nxt = ACTIVE;
    end else if (state == ACTIVE && next) begin
      advance = 1'b1;
      if (cnt == LAST_IDX) state_nxt = DONE;
    end
  end

  assign word_new = key_q[0:SIDE_SIZE-1] + s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key_q <= '0;
      s_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        key_q <= key_in;
        s_q   <= DELTA;
        cnt   <= '0;
      end else if (advance) begin
        // word-wise left rotate with the leading word replaced by the mixed word
        key_q <= {key_q[SIDE_SIZE:KEY_SIZE-1], word_new};
        s_q   <= s_q + DELTA;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign rk        = key_q[0:SIDE_SIZE-1];
  assign rk_en     = (state == ACTIVE);
  assign round_idx = cnt;
  assign last      = (state == ACTIVE) && (cnt == LAST_IDX);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_serial_key_schedule.sv
// Self-checking bench for serial_key_schedule: table-driven vectors plus
// hand-written sequences for the full schedule and mid-schedule reset.
module tb_serial_key_schedule;

  localparam logic [127:0] KEY_A = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] KEY_F = 128'hFFFFFFFF_00000000_00000000_00000000;
  localparam logic [31:0]  DELTA = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [0:127]  key_in = '0;
  logic          next = 1'b0;
  logic [0:31]   rk;
  logic          rk_en;
  logic [5:0]    round_idx;
  logic          last;
  logic          done;

  int errors = 0;
  int checks = 0;

  serial_key_schedule dut (
    .clk(clk), .rst(rst), .load(load), .key_in(key_in), .next(next),
    .rk(rk), .rk_en(rk_en), .round_idx(round_idx), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, load, next;
    logic [127:0] key;
    logic [31:0]  rk;
    logic         en;
    logic [5:0]   idx;
    logic         last, done;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r, logic l, logic n, logic [127:0] k,
                              logic [31:0] erk, logic een, logic [5:0] eidx,
                              logic elast, logic edone);
    vec_t v;
    v.rst = r; v.load = l; v.next = n; v.key = k;
    v.rk = erk; v.en = een; v.idx = eidx; v.last = elast; v.done = edone;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic l, logic n, logic [127:0] k);
    rst = r; load = l; next = n; key_in = k;
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; next = 1'b0;
  endtask

  task automatic check_outs(string tag, logic [31:0] erk, logic een,
                            logic [5:0] eidx, logic elast, logic edone);
    chk({tag, ".rk"},    64'(rk),        64'(erk));
    chk({tag, ".rk_en"}, 64'(rk_en),     64'(een));
    chk({tag, ".idx"},   64'(round_idx), 64'(eidx));
    chk({tag, ".last"},  64'(last),      64'(elast));
    chk({tag, ".done"},  64'(done),      64'(edone));
  endtask

  task automatic run_vec(int i);
    step(tbl[i].rst, tbl[i].load, tbl[i].next, tbl[i].key);
    check_outs($sformatf("vec%0d", i), tbl[i].rk, tbl[i].en, tbl[i].idx,
               tbl[i].last, tbl[i].done);
  endtask

  logic [31:0] m_w[4];
  logic [31:0] m_s;
  logic [31:0] w_tmp;
  logic [31:0] rk_hold;

  initial begin
    // reset with load and next held high, then a lone next in IDLE
    tbl[0]  = mk(1, 1, 1, KEY_A, 32'h0,        0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, KEY_A, 32'h0,        0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, KEY_A, 32'h0,        0, 0, 0, 0);
    // load and first keys
    tbl[3]  = mk(0, 1, 0, KEY_A, 32'h00010203, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, KEY_A, 32'h04050607, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, KEY_A, 32'h08090A0B, 1, 2, 0, 0);
    tbl[6]  = mk(0, 0, 1, KEY_A, 32'h0C0D0E0F, 1, 3, 0, 0);
    tbl[7]  = mk(0, 0, 1, KEY_A, 32'h9E387BBC, 1, 4, 0, 0);
    tbl[8]  = mk(0, 0, 1, KEY_A, 32'h4073F979, 1, 5, 0, 0);
    tbl[9]  = mk(0, 0, 0, KEY_A, 32'h4073F979, 1, 5, 0, 0);
    // load+next at round 5: next dropped, then carry wrap on all-F leading word
    tbl[10] = mk(0, 1, 1, KEY_F, 32'hFFFFFFFF, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, KEY_F, 32'h00000000, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, KEY_F, 32'h00000000, 1, 2, 0, 0);
    tbl[13] = mk(0, 0, 1, KEY_F, 32'h00000000, 1, 3, 0, 0);
    tbl[14] = mk(0, 0, 1, KEY_F, 32'h9E3779B8, 1, 4, 0, 0);

    for (int i = 0; i < 15; i++) run_vec(i);

    // full schedule against a word-level model
    step(0, 1, 0, KEY_A);
    m_w[0] = KEY_A[127:96]; m_w[1] = KEY_A[95:64];
    m_w[2] = KEY_A[63:32];  m_w[3] = KEY_A[31:0];
    m_s = DELTA;
    for (int r = 0; r < 32; r++) begin
      check_outs($sformatf("full%0d", r), m_w[0], 1'b1, 6'(r), r == 31, 1'b0);
      w_tmp = m_w[0] + m_s;
      m_w[0] = m_w[1]; m_w[1] = m_w[2]; m_w[2] = m_w[3]; m_w[3] = w_tmp;
      m_s = m_s + DELTA;
      step(0, 0, 1, KEY_A);
    end
    check_outs("done", m_w[0], 1'b0, 6'd32, 1'b0, 1'b1);
    rk_hold = m_w[0];
    step(0, 0, 1, KEY_A);
    check_outs("done_next", rk_hold, 1'b0, 6'd32, 1'b0, 1'b1);

    // reset mid-schedule at round 10, then replay the load sequence
    step(0, 1, 0, KEY_A);
    for (int r = 0; r < 10; r++) step(0, 0, 1, KEY_A);
    chk("mid.idx_before_rst", 64'(round_idx), 64'd10);
    step(1, 0, 0, KEY_A);
    check_outs("midrst", 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 3; i <= 8; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
